// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 8N1 UART receiver with an AXI4-Stream master output.
// One bit period is max(prescale,1)*8 clk cycles. Bits are sampled mid-bit,
// timed from the synchronised falling edge of the start bit.
// Optional build macro UART_RX_BREAK_EN adds the break_det output, which flags
// an all-zero frame with a low stop bit (a line break).
module uart_rx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
`ifdef UART_RX_BREAK_EN
  ,
  output logic                  break_det
`endif
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t                r_state;
  logic                  r_rxd_meta;
  logic                  r_rxs;
  logic [18:0]           r_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_busy;
  logic                  r_overrun;
  logic                  r_frame_error;

  logic [15:0] w_p;
  logic [18:0] w_half_reload;
  logic [18:0] w_bit_reload;
  logic        w_cnt_zero;

  // Effective prescale and counter reload values (19 bits so 0xFFFF*8 fits).
  assign w_p           = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_half_reload = (19'(w_p) << 2) - 19'd1;
  assign w_bit_reload  = (19'(w_p) << 3) - 19'd1;
  assign w_cnt_zero    = (r_cnt == 19'd0);

  // Two-flop synchroniser for the asynchronous rxd pin; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxs      <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxs      <= r_rxd_meta;
    end
  end

  // Receive FSM, output register and stream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register and bit counter are reset too; they are a few
      // flops, and a defined value keeps break detection and debug dumps clean.
      r_state       <= ST_ARM;
      r_cnt         <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; the later STOP load below must
      // override the handshake clear, which relies on last-assignment-wins.
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
      if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        ST_ARM: begin
          if (r_rxs) begin
            r_state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (!r_rxs) begin
            r_cnt   <= w_half_reload;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_cnt_zero) begin
            if (r_rxs) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt     <= w_bit_reload;
              r_bit_cnt <= BW'(DATA_WIDTH);
              r_state   <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt - 19'd1;
          end
        end

        ST_DATA: begin
          if (w_cnt_zero) begin
            r_shift   <= {r_rxs, r_shift[DATA_WIDTH-1:1]};
            r_cnt     <= w_bit_reload;
            r_bit_cnt <= r_bit_cnt - BW'(1);
            if (r_bit_cnt == BW'(1)) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt - 19'd1;
          end
        end

        ST_STOP: begin
          if (w_cnt_zero) begin
            r_busy <= 1'b0;
            if (r_rxs) begin
              r_tdata   <= r_shift;
              r_tvalid  <= 1'b1;
              r_overrun <= r_tvalid && !m_axis_tready;
              r_state   <= ST_IDLE;
            end else begin
              r_frame_error <= 1'b1;
              r_state       <= ST_ARM;
            end
          end else begin
            r_cnt <= r_cnt - 19'd1;
          end
        end

        default: r_state <= ST_ARM;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign busy          = r_busy;
  assign overrun_error = r_overrun;
  assign frame_error   = r_frame_error;

`ifdef UART_RX_BREAK_EN
  logic r_break;

  // Break flag: set on an all-zero frame with a low stop bit, held until the
  // line returns high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_break <= 1'b0;
    end else if (r_state == ST_STOP && w_cnt_zero && !r_rxs && r_shift == '0) begin
      r_break <= 1'b1;
    end else if (r_rxs) begin
      r_break <= 1'b0;
    end
  end

  assign break_det = r_break;
`endif

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: scoreboard bench for uart_rx_axis. Stimulus builds 8N1
// waveforms from bytes and pushes each byte that must be delivered; a monitor
// pops and compares on every accepted stream beat and counts status pulses.
module tb_uart_rx_axis;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy;
  logic       overrun_error;
  logic       frame_error;
  logic [15:0] prescale = 16'd2;
`ifdef UART_RX_BREAK_EN
  logic       break_det;
`endif

  int   ready_mode = 1;   // 0: low, 1: high, 2: random per cycle
  logic ready_rnd  = 1'b1;
  assign m_axis_tready = (ready_mode == 2) ? ready_rnd : (ready_mode == 1);

  uart_rx_axis #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .prescale      (prescale)
`ifdef UART_RX_BREAK_EN
    ,
    .break_det     (break_det)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 ready_rnd = 1'($urandom_range(0, 1));
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  int cnt_busy  = 0;
  int cnt_valid = 0;
  int cnt_ferr  = 0;
  int cnt_ovr   = 0;
  int cnt_beats = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard compare on each accepted beat, plus pulse counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) cnt_busy++;
      if (m_axis_tvalid) cnt_valid++;
      if (frame_error) cnt_ferr++;
      if (overrun_error) cnt_ovr++;
      if (m_axis_tvalid && m_axis_tready) begin
        cnt_beats++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got 0x%0h expected none at %0t", m_axis_tdata, $time);
        end else begin
          check("beat_data", m_axis_tdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame; rxd is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int p);
    int bt;
    bt = ((p == 0) ? 1 : p) * 8;
    prescale = 16'(p);
    rxd = 1'b0;
    step(bt);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      step(bt);
    end
    rxd = stop_bit;
    step(bt);
  endtask

  int b0, v0, f0, o0, n0;

  task automatic snap();
    b0 = cnt_busy; v0 = cnt_valid; f0 = cnt_ferr; o0 = cnt_ovr; n0 = cnt_beats;
  endtask

  initial begin
    step(1);
    step(3);
    // Reset state
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun_error, 0);
    check("rst_ferr", frame_error, 0);
    rst = 1'b0;
    step(10);

    // Byte 0x55, prescale 2, tready high
    snap();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 2);
    step(20);
    check("b55_busy_cycles", cnt_busy - b0, 152);
    check("b55_valid_cycles", cnt_valid - v0, 1);
    check("b55_beats", cnt_beats - n0, 1);
    check("b55_errors", (cnt_ferr - f0) + (cnt_ovr - o0), 0);

    // Back-pressure and overrun: 0xA3 is overwritten by 0x3C
    ready_mode = 0;
    snap();
    send_frame(8'hA3, 1'b1, 2);
    check("bp_valid_first", m_axis_tvalid, 1);
    check("bp_data_first", m_axis_tdata, 8'hA3);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 2);
    step(5);
    check("bp_ovr_pulses", cnt_ovr - o0, 1);
    check("bp_data_second", m_axis_tdata, 8'h3C);
    check("bp_valid_held", m_axis_tvalid, 1);
    ready_mode = 1;
    step(1);
    check("bp_valid_drop", m_axis_tvalid, 0);
    check("bp_beats", cnt_beats - n0, 1);

    // Framing error, then the block waits in ARM while rxd stays low
    step(20);
    snap();
    send_frame(8'h81, 1'b0, 2);
    b0 = cnt_busy;
    step(100);
    check("fe_pulses", cnt_ferr - f0, 1);
    check("fe_no_valid", cnt_valid - v0, 0);
    check("fe_arm_no_busy", cnt_busy - b0, 0);
    rxd = 1'b1;
    step(20);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 2);
    step(20);
    check("fe_next_beat", cnt_beats - n0, 1);

    // Start glitch at prescale 4
    snap();
    prescale = 16'd4;
    rxd = 1'b0;
    step(10);
    rxd = 1'b1;
    step(40);
    check("gl_busy_now", busy, 0);
    check("gl_busy_cycles", cnt_busy - b0, 16);
    check("gl_no_valid", cnt_valid - v0, 0);
    check("gl_no_err", (cnt_ferr - f0) + (cnt_ovr - o0), 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 4);
    step(20);
    check("gl_next_beat", cnt_beats - n0, 1);

    // Reset during bit 3 of 0xF0, rxd held low afterwards
    snap();
    prescale = 16'd2;
    rxd = 1'b0;
    step(16 * 4 + 8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mr_tvalid", m_axis_tvalid, 0);
    check("mr_busy", busy, 0);
    check("mr_tdata", m_axis_tdata, 0);
    check("mr_ferr", frame_error, 0);
    snap();
    step(300);
    check("mr_low_no_valid", cnt_valid - v0, 0);
    check("mr_low_no_ovr", cnt_ovr - o0, 0);
    rxd = 1'b1;
    step(20);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 2);
    step(20);
    check("mr_next_beat", cnt_beats - n0, 1);

    // Line break: rxd low for two frames at prescale 2
    snap();
    rxd = 1'b0;
    step(320);
    check("brk_ferr_pulses", cnt_ferr - f0, 1);
    check("brk_no_valid", cnt_valid - v0, 0);
`ifdef UART_RX_BREAK_EN
    check("brk_det_high", break_det, 1);
`endif
    rxd = 1'b1;
    step(2);
`ifdef UART_RX_BREAK_EN
    check("brk_det_hold", break_det, 1);
`endif
    step(1);
`ifdef UART_RX_BREAK_EN
    check("brk_det_clear", break_det, 0);
`endif
    step(20);

    // Randomised frames, prescales and tready
    ready_mode = 2;
    snap();
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      int p;
      d = 8'($urandom);
      p = $urandom_range(0, 3);
      exp_q.push_back(d);
      send_frame(d, 1'b1, p);
      step($urandom_range(0, 15));
    end
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) step(1);
    check("rnd_drain", exp_q.size(), 0);
    check("rnd_beats", cnt_beats - n0, 24);
    check("rnd_no_err", (cnt_ferr - f0) + (cnt_ovr - o0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
